// File: rtl/i2c_pkt_parser_pkg.sv
// Shared types for the I2C slave path: front-end event kinds plus the
// packet framer's states, error codes and header field layout.
package i2c_pkt_parser_pkg;

    typedef enum logic [1:0] {
        EV_START = 2'd0,
        EV_STOP  = 2'd1,
        EV_DATA  = 2'd2,
        EV_ADDR  = 2'd3
    } i2c_state_t;

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } i2c_op_t;

    typedef enum logic [3:0] {
        HT_CTRL    = 4'h1,
        HT_STATUS  = 4'h2,
        HT_PAYLOAD = 4'h4,
        HT_EVENT   = 4'h8
    } header_type_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_WAIT,
        ST_HEADER,
        ST_BODY,
        ST_DISCARD
    } pkt_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BAD_SEQ = 2'd1,
        ERR_BAD_HDR = 2'd2,
        ERR_TRUNC   = 2'd3
    } err_code_t;

    localparam int HDR_TYPE_MSB = 7;
    localparam int HDR_TYPE_LSB = 4;
    localparam int HDR_LEN_MSB  = 3;
    localparam int HDR_LEN_LSB  = 0;

    // A header type nibble is legal only when exactly one bit is set.
    function automatic logic is_one_hot4(input logic [3:0] n);
        return (n != 4'h0) && ((n & (n - 4'h1)) == 4'h0);
    endfunction

endpackage

// File: rtl/i2c_pkt_sat_counter.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
module i2c_pkt_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc && (count != {CNT_W{1'b1}}))
            count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
    end

endmodule

// File: rtl/i2c_pkt_parser.sv
// Frames WRITE bytes addressed to this slave into header+payload packets
// and streams them out through a single registered output stage.
module i2c_pkt_parser #(
    parameter logic [6:0] SLAVE_ADDR = 7'h22,
    parameter int         CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_kind,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [3:0]       out_type,
    output logic             out_sop,
    output logic             out_eop,
    output logic             out_abort,
    output logic             err_o,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    import i2c_pkt_parser_pkg::*;

    pkt_state_t state;
    i2c_state_t kind;
    logic [3:0] remaining;
    logic [3:0] hdr_type;
    logic [3:0] hdr_len;
    logic       accept;
    logic       addr_hit;
    logic       pkt_done;

    // The output register is the only buffer, so every event kind stalls on it.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign kind     = i2c_state_t'(in_kind);
    assign hdr_type = in_data[HDR_TYPE_MSB:HDR_TYPE_LSB];
    assign hdr_len  = in_data[HDR_LEN_MSB:HDR_LEN_LSB];
    assign addr_hit = (in_data[7:1] == SLAVE_ADDR) && (in_data[0] == OP_WRITE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            remaining <= 4'h0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_type  <= HT_PAYLOAD;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_abort <= 1'b0;
            err_o     <= 1'b0;
            err_code  <= ERR_NONE;
            pkt_done  <= 1'b0;
        end else begin
            err_o    <= 1'b0;
            pkt_done <= 1'b0;
            if (out_ready)
                out_valid <= 1'b0;
            if (accept) begin
                case (state)
                    ST_IDLE:
                        if (kind == EV_START) state <= ST_ADDR_WAIT;
                    ST_ADDR_WAIT:
                        case (kind)
                            EV_ADDR:  state <= addr_hit ? ST_HEADER : ST_DISCARD;
                            EV_DATA: begin
                                err_o    <= 1'b1;
                                err_code <= ERR_BAD_SEQ;
                                state    <= ST_DISCARD;
                            end
                            EV_STOP:  state <= ST_IDLE;
                            default:  state <= ST_ADDR_WAIT;
                        endcase
                    ST_HEADER:
                        case (kind)
                            EV_DATA:
                                if (is_one_hot4(hdr_type)) begin
                                    out_valid <= 1'b1;
                                    out_data  <= in_data;
                                    out_type  <= hdr_type;
                                    out_sop   <= 1'b1;
                                    out_eop   <= (hdr_len == 4'h0);
                                    out_abort <= 1'b0;
                                    remaining <= hdr_len;
                                    if (hdr_len == 4'h0) pkt_done <= 1'b1;
                                    else                 state    <= ST_BODY;
                                end else begin
                                    err_o    <= 1'b1;
                                    err_code <= ERR_BAD_HDR;
                                    state    <= ST_DISCARD;
                                end
                            EV_STOP:  state <= ST_IDLE;
                            EV_START: state <= ST_ADDR_WAIT;
                            default: begin
                                err_o    <= 1'b1;
                                err_code <= ERR_BAD_SEQ;
                                state    <= ST_DISCARD;
                            end
                        endcase
                    ST_BODY:
                        if (kind == EV_DATA) begin
                            out_valid <= 1'b1;
                            out_data  <= in_data;
                            out_sop   <= 1'b0;
                            out_eop   <= (remaining == 4'h1);
                            out_abort <= 1'b0;
                            remaining <= remaining - 4'h1;
                            if (remaining == 4'h1) begin
                                pkt_done <= 1'b1;
                                state    <= ST_HEADER;
                            end
                        end else begin
                            // Packet cut short: close it downstream with an abort marker.
                            out_valid <= 1'b1;
                            out_data  <= 8'h00;
                            out_sop   <= 1'b0;
                            out_eop   <= 1'b1;
                            out_abort <= 1'b1;
                            err_o     <= 1'b1;
                            err_code  <= ERR_TRUNC;
                            remaining <= 4'h0;
                            state     <= (kind == EV_STOP)  ? ST_IDLE :
                                         (kind == EV_START) ? ST_ADDR_WAIT : ST_DISCARD;
                        end
                    ST_DISCARD:
                        if (kind == EV_STOP)       state <= ST_IDLE;
                        else if (kind == EV_START) state <= ST_ADDR_WAIT;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    i2c_pkt_sat_counter #(.CNT_W(CNT_W)) u_pkt_cnt (
        .clk(clk), .rst_n(rst_n), .inc(pkt_done), .count(pkt_cnt)
    );

    i2c_pkt_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk(clk), .rst_n(rst_n), .inc(err_o), .count(err_cnt)
    );

endmodule

// File: tb/tb_i2c_pkt_parser.sv
// Bench for i2c_pkt_parser: directed vector table, stall and reset
// sequences, then random event streams scored against a packet model.
module tb_i2c_pkt_parser;

    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;
    localparam logic [1:0] K_S = 2'd0, K_P = 2'd1, K_D = 2'd2, K_A = 2'd3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_kind = 2'd0;
    logic [7:0]       in_data = 8'h00;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [7:0]       out_data;
    logic [3:0]       out_type;
    logic             out_sop, out_eop, out_abort;
    logic             err_o;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] pkt_cnt, err_cnt;

    i2c_pkt_parser #(.SLAVE_ADDR(7'h22), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_type(out_type), .out_sop(out_sop), .out_eop(out_eop), .out_abort(out_abort),
        .err_o(err_o), .err_code(err_code), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // ---------------- monitor: beats {data,type,sop,eop,abort} and error codes
    logic [14:0] act_q[$], exp_q[$];
    logic [1:0]  act_eq[$], exp_eq[$];

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready)
            act_q.push_back({out_data, out_type, out_sop, out_eop, out_abort});
        if (rst_n && err_o)
            act_eq.push_back(err_code);
    end

    bit rand_ready = 1'b0;
    initial forever begin
        @(posedge clk); #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [1:0] k, input logic [7:0] d);
        int w = 0;
        in_valid = 1'b1; in_kind = k; in_data = d;
        @(negedge clk);
        while (!in_ready && w < 100) begin w++; @(negedge clk); end
        if (!in_ready) begin
            n_chk++;
            $display("FAIL send_timeout: in_ready 0 after %0d cycles, required 1", w);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // ---------------- reference model: transaction-level view of the stream
    int   m_phase;   // 0 no txn, 1 expecting address, 2 write to us, 3 ignoring
    int   m_left;    // payload bytes still owed by the open packet
    logic [3:0] m_type;
    int   m_pkts, m_errs;

    task automatic m_abort();
        exp_q.push_back({8'h00, m_type, 1'b0, 1'b1, 1'b1});
        exp_eq.push_back(2'd3);
        m_errs++;
    endtask

    task automatic m_err(input logic [1:0] c);
        exp_eq.push_back(c);
        m_errs++;
    endtask

    task automatic model(input logic [1:0] k, input logic [7:0] d);
        logic [3:0] t, len;
        t = d[7:4]; len = d[3:0];
        case (k)
            K_S, K_P: begin
                if (m_phase == 2 && m_left > 0) m_abort();
                m_phase = (k == K_S) ? 1 : 0;
                m_left  = 0;
            end
            K_A: begin
                if (m_phase == 1)
                    m_phase = (d == 8'h44) ? 2 : 3;
                else if (m_phase == 2) begin
                    if (m_left > 0) m_abort(); else m_err(2'd1);
                    m_phase = 3; m_left = 0;
                end
            end
            default: begin
                if (m_phase == 1) begin
                    m_err(2'd1); m_phase = 3;
                end else if (m_phase == 2) begin
                    if (m_left > 0) begin
                        exp_q.push_back({d, m_type, 1'b0, m_left == 1, 1'b0});
                        m_left--;
                        if (m_left == 0) m_pkts++;
                    end else if ($countones(t) == 1) begin
                        m_type = t;
                        exp_q.push_back({d, t, 1'b1, len == 0, 1'b0});
                        m_left = int'(len);
                        if (len == 0) m_pkts++;
                    end else begin
                        m_err(2'd2); m_phase = 3;
                    end
                end
            end
        endcase
    endtask

    function automatic int sat(input int x);
        return (x > SAT) ? SAT : x;
    endfunction

    task automatic drain_and_compare(input string tag);
        int w = 0;
        int n;
        rand_ready = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        while (out_valid && w < 50) begin w++; @(negedge clk); end
        repeat (3) @(negedge clk);
        chk({tag, "_beat_count"}, 32'(act_q.size()), 32'(exp_q.size()));
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (act_q[i] !== exp_q[i]) chk({tag, "_beat"}, 32'(act_q[i]), 32'(exp_q[i]));
            else chk({tag, "_beat"}, 32'(act_q[i]), 32'(exp_q[i]));
        chk({tag, "_err_count"}, 32'(act_eq.size()), 32'(exp_eq.size()));
        n = (act_eq.size() < exp_eq.size()) ? act_eq.size() : exp_eq.size();
        for (int i = 0; i < n; i++) chk({tag, "_err_code"}, 32'(act_eq[i]), 32'(exp_eq[i]));
        chk({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'(sat(m_pkts)));
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(sat(m_errs)));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
        chk({tag, "_out_type"},  32'(out_type),  32'h4);
        chk({tag, "_out_misc"},  32'({out_data, out_sop, out_eop, out_abort, err_o, err_code}), 32'd0);
        chk({tag, "_counters"},  32'({pkt_cnt, err_cnt}), 32'd0);
    endtask

    // ---------------- directed vector table
    typedef struct {
        logic [1:0] kind;
        logic [7:0] data;
        logic       beat;
        logic [7:0] odata;
        logic [3:0] otype;
        logic       sop, eop, abort;
        logic       err;
        logic [1:0] code;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t ev(input logic [1:0] k, input logic [7:0] d);
        vec_t v;
        v = '{kind: k, data: d, beat: 1'b0, odata: 8'h00, otype: 4'h0,
              sop: 1'b0, eop: 1'b0, abort: 1'b0, err: 1'b0, code: 2'd0};
        return v;
    endfunction

    function automatic vec_t bt(input logic [1:0] k, input logic [7:0] d, input logic [7:0] od,
                                input logic [3:0] ot, input logic s, input logic e, input logic a,
                                input logic er, input logic [1:0] c);
        vec_t v;
        v = '{kind: k, data: d, beat: 1'b1, odata: od, otype: ot,
              sop: s, eop: e, abort: a, err: er, code: c};
        return v;
    endfunction

    function automatic vec_t er(input logic [1:0] k, input logic [7:0] d, input logic [1:0] c);
        vec_t v;
        v = ev(k, d);
        v.err = 1'b1; v.code = c;
        return v;
    endfunction

    initial begin
        // write: header 0x42 (type 4, len 2) and two payload bytes
        tbl.push_back(ev(K_S, 8'h00)); tbl.push_back(ev(K_A, 8'h44));
        tbl.push_back(bt(K_D, 8'h42, 8'h42, 4'h4, 1, 0, 0, 0, 2'd0));
        tbl.push_back(bt(K_D, 8'hA1, 8'hA1, 4'h4, 0, 0, 0, 0, 2'd0));
        tbl.push_back(bt(K_D, 8'hB2, 8'hB2, 4'h4, 0, 1, 0, 0, 2'd0));
        tbl.push_back(ev(K_P, 8'h00));
        // read, then write to another address: silently ignored
        tbl.push_back(ev(K_S, 8'h00)); tbl.push_back(ev(K_A, 8'h45));
        tbl.push_back(ev(K_D, 8'h10)); tbl.push_back(ev(K_P, 8'h00));
        tbl.push_back(ev(K_S, 8'h00)); tbl.push_back(ev(K_A, 8'h46));
        tbl.push_back(ev(K_D, 8'h42)); tbl.push_back(ev(K_P, 8'h00));
        // bad header nibble, following data dropped
        tbl.push_back(ev(K_S, 8'h00)); tbl.push_back(ev(K_A, 8'h44));
        tbl.push_back(er(K_D, 8'h30, 2'd2)); tbl.push_back(ev(K_D, 8'h10));
        tbl.push_back(ev(K_P, 8'h00));
        // truncated packet closed with abort marker
        tbl.push_back(ev(K_S, 8'h00)); tbl.push_back(ev(K_A, 8'h44));
        tbl.push_back(bt(K_D, 8'h83, 8'h83, 4'h8, 1, 0, 0, 0, 2'd0));
        tbl.push_back(bt(K_D, 8'h01, 8'h01, 4'h8, 0, 0, 0, 0, 2'd0));
        tbl.push_back(bt(K_P, 8'h00, 8'h00, 4'h8, 0, 1, 1, 1, 2'd3));
        // two zero-length packets in one transaction
        tbl.push_back(ev(K_S, 8'h00)); tbl.push_back(ev(K_A, 8'h44));
        tbl.push_back(bt(K_D, 8'h10, 8'h10, 4'h1, 1, 1, 0, 0, 2'd0));
        tbl.push_back(bt(K_D, 8'h20, 8'h20, 4'h2, 1, 1, 0, 0, 2'd0));
        tbl.push_back(ev(K_P, 8'h00));
        // DATA where address expected; ADDR where header expected
        tbl.push_back(ev(K_S, 8'h00)); tbl.push_back(er(K_D, 8'h55, 2'd1));
        tbl.push_back(ev(K_P, 8'h00));
        tbl.push_back(ev(K_S, 8'h00)); tbl.push_back(ev(K_A, 8'h44));
        tbl.push_back(er(K_A, 8'h44, 2'd1)); tbl.push_back(ev(K_P, 8'h00));
        // idle data ignored; repeated START truncates then restarts matching
        tbl.push_back(ev(K_D, 8'h42));
        tbl.push_back(ev(K_S, 8'h00)); tbl.push_back(ev(K_A, 8'h44));
        tbl.push_back(bt(K_D, 8'h12, 8'h12, 4'h1, 1, 0, 0, 0, 2'd0));
        tbl.push_back(bt(K_S, 8'h00, 8'h00, 4'h1, 0, 1, 1, 1, 2'd3));
        tbl.push_back(ev(K_A, 8'h44));
        tbl.push_back(bt(K_D, 8'h80, 8'h80, 4'h8, 1, 1, 0, 0, 2'd0));
        tbl.push_back(ev(K_P, 8'h00));

        #12; check_reset("reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            send(tbl[i].kind, tbl[i].data);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].beat));
            if (tbl[i].beat)
                chk($sformatf("vec%0d_beat", i),
                    32'({out_data, out_type, out_sop, out_eop, out_abort}),
                    32'({tbl[i].odata, tbl[i].otype, tbl[i].sop, tbl[i].eop, tbl[i].abort}));
            chk($sformatf("vec%0d_err", i), 32'(err_o), 32'(tbl[i].err));
            if (tbl[i].err)
                chk($sformatf("vec%0d_code", i), 32'(err_code), 32'(tbl[i].code));
        end
        repeat (3) @(negedge clk);
        chk("table_pkt_cnt", 32'(pkt_cnt), 32'd4);
        chk("table_err_cnt", 32'(err_cnt), 32'd5);

        // stall: downstream holds off for 5 cycles after the header beat
        m_phase = 0; m_left = 0; m_type = 4'h4; m_pkts = 4; m_errs = 5;
        act_q.delete(); act_eq.delete();
        send(K_S, 8'h00); model(K_S, 8'h00);
        send(K_A, 8'h44); model(K_A, 8'h44);
        send(K_D, 8'h42); model(K_D, 8'h42);
        out_ready = 1'b0;
        fork
            begin
                send(K_D, 8'hA1); model(K_D, 8'hA1);
                send(K_D, 8'hB2); model(K_D, 8'hB2);
                send(K_P, 8'h00); model(K_P, 8'h00);
            end
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                    chk("stall_hold", 32'({out_valid, out_data, out_sop}), 32'({1'b1, 8'h42, 1'b1}));
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain_and_compare("stall");

        // random event streams with random backpressure
        act_q.delete(); act_eq.delete(); exp_q.delete(); exp_eq.delete();
        rand_ready = 1'b1;
        for (int n = 0; n < 600; n++) begin
            int r;
            logic [1:0] k;
            logic [7:0] d;
            logic [3:0] t;
            r = $urandom_range(0, 99);
            d = 8'($urandom);
            if (r < 8) k = K_S;
            else if (r < 14) k = K_P;
            else if (r < 21) begin
                k = K_A;
                if ($urandom_range(0, 3) != 0) d = 8'h44;
            end else begin
                k = K_D;
                if ($urandom_range(0, 4) != 0) begin
                    t = 4'b0001 << $urandom_range(0, 3);
                    d = {t, 4'($urandom_range(0, 3))};
                end
            end
            send(k, d);
            model(k, d);
        end
        drain_and_compare("rand");

        // reset with a beat pending: beat dropped, everything back to idle
        @(posedge clk); #2;
        out_ready = 1'b0;
        send(K_S, 8'h00); send(K_A, 8'h44); send(K_D, 8'h83);
        chk("pre_reset_pending", 32'(out_valid), 32'd1);
        @(negedge clk); rst_n = 1'b0;
        #1; check_reset("midreset");
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        send(K_D, 8'h01);
        chk("post_reset_idle", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
